// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter sweep controller and its counter partner.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package counter_pkg;

  localparam int CNT_WIDTH = 4;
  localparam int CNT_NSW_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    UP,
    DOWN,
    DONE
  } state_t;

  // One clock edge of the attached counter: load wins, otherwise step up or down (wraps).
  function automatic logic [CNT_WIDTH-1:0] next_count(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 ld,
    input logic [CNT_WIDTH-1:0] din,
    input logic                 ud
  );
    if (ld) begin
      return din;
    end else if (ud) begin
      return cur + 1'b1;
    end else begin
      return cur - 1'b1;
    end
  endfunction

endpackage

// File: rtl/updown_counter.sv
// Loadable up/down counter driven by the sweep controller.
// Latency: one edge from load/UD to out.
// Backpressure: none; counts every cycle it is not held in reset.
module updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] entrada,
  input  logic             UD,
  output logic [WIDTH-1:0] out
);

  // Load takes priority; otherwise count in the direction given by UD.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out <= '0;
    end else if (load) begin
      out <= entrada;
    end else if (UD) begin
      out <= out + 1'b1;
    end else begin
      out <= out - 1'b1;
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Loads a low bound into the counter, sweeps it low->high->low N times and checks every count.
// Latency: 2 + 2*(H-L)*N busy cycles, then a one-cycle done pulse; rejected requests pulse done next cycle.
// Backpressure: start is only sampled in IDLE; requests while busy or in DONE are dropped.
module counter_sweep_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int NSW_W = CNT_NSW_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_low,
  input  logic [WIDTH-1:0] i_high,
  input  logic [NSW_W-1:0] i_n_sweeps,
  input  logic [WIDTH-1:0] i_cnt_in,
  output logic             o_load,
  output logic [WIDTH-1:0] o_entrada,
  output logic             o_UD,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [NSW_W-1:0] o_sweeps_done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] w_exp_nxt;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [NSW_W-1:0] r_n;
  logic [NSW_W-1:0] r_sweeps;
  logic [NSW_W-1:0] w_sweeps_nxt;
  logic             r_error;
  logic             w_error_nxt;
  logic             w_accept;
  logic             w_mismatch;
  logic             w_last;

  assign w_mismatch    = (i_cnt_in != r_exp);
  // Finishing the current round trip would reach the requested count.
  assign w_last        = ((r_sweeps + 1'b1) == r_n);
  assign o_error       = r_error;
  assign o_sweeps_done = r_sweeps;

  // State, expected count, sweep counter and sticky error; bounds latched on an accepted start.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_exp    <= '0;
      r_sweeps <= '0;
      r_error  <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_n      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_exp    <= w_exp_nxt;
      r_sweeps <= w_sweeps_nxt;
      r_error  <= w_error_nxt;
      if (w_accept) begin
        r_lo <= i_low;
        r_hi <= i_high;
        r_n  <= i_n_sweeps;
      end
    end
  end

  // Next-state and output decode; counter controls depend only on registered state.
  always_comb begin
    w_state_nxt  = r_state;
    w_exp_nxt    = r_exp;
    w_sweeps_nxt = r_sweeps;
    w_error_nxt  = r_error;
    w_accept     = 1'b0;
    o_load       = 1'b0;
    o_entrada    = '0;
    o_UD         = 1'b1;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          if ((i_low < i_high) && (i_n_sweeps != '0)) begin
            w_accept     = 1'b1;
            w_error_nxt  = 1'b0;
            w_sweeps_nxt = '0;
            w_state_nxt  = LOAD;
          end else begin
            w_error_nxt = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      LOAD: begin
        o_load      = 1'b1;
        o_entrada   = r_lo;
        o_busy      = 1'b1;
        w_exp_nxt   = next_count(r_exp, 1'b1, r_lo, 1'b1);
        w_state_nxt = UP;
      end
      UP: begin
        o_busy = 1'b1;
        o_UD   = (r_exp != r_hi);
        if (w_mismatch) begin
          w_error_nxt = 1'b1;
          w_state_nxt = DONE;
        end else if (r_exp != r_hi) begin
          w_exp_nxt = next_count(r_exp, 1'b0, '0, 1'b1);
        end else begin
          w_exp_nxt   = next_count(r_hi, 1'b0, '0, 1'b0);
          w_state_nxt = DOWN;
        end
      end
      DOWN: begin
        o_busy = 1'b1;
        // Turn the counter around at the low bound unless this trip is the last one.
        o_UD   = (r_exp == r_lo) && !w_last;
        if (w_mismatch) begin
          w_error_nxt = 1'b1;
          w_state_nxt = DONE;
        end else if (r_exp != r_lo) begin
          w_exp_nxt = next_count(r_exp, 1'b0, '0, 1'b0);
        end else begin
          w_sweeps_nxt = r_sweeps + 1'b1;
          if (w_last) begin
            w_state_nxt = DONE;
          end else begin
            w_exp_nxt   = next_count(r_lo, 1'b0, '0, 1'b1);
            w_state_nxt = UP;
          end
        end
      end
      DONE: begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Randomized scoreboard bench: sweep controller driving a real up/down counter.
module tb_counter_sweep_ctrl;
  import counter_pkg::*;

  typedef struct {
    int busy;
    int sweeps;
    int err;
    int loads;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] low = '0;
  logic [3:0] high = '0;
  logic [3:0] nsw = '0;
  logic       force_zero = 1'b0;
  logic [3:0] cnt_out;
  logic [3:0] cnt_in;
  logic       load;
  logic [3:0] entrada;
  logic       ud;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] sweeps_done;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [3:0] seq[$];
  int   model_sweeps = 0;
  int   tb_low = 0;
  int   mon_busy = 0;
  int   mon_loads = 0;

  always #5 clk = ~clk;

  assign cnt_in = force_zero ? 4'd0 : cnt_out;

  counter_sweep_ctrl #(.WIDTH(4), .NSW_W(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_low(low), .i_high(high),
    .i_n_sweeps(nsw), .i_cnt_in(cnt_in), .o_load(load), .o_entrada(entrada),
    .o_UD(ud), .o_busy(busy), .o_done(done), .o_error(error), .o_sweeps_done(sweeps_done)
  );

  updown_counter #(.WIDTH(4)) u_cnt (
    .clk(clk), .arst_n(~rst), .load(load), .entrada(entrada), .UD(ud), .out(cnt_out)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: checks every busy cycle against the expected count sequence and
  // pops one run record on each done pulse.
  always @(negedge clk) begin
    if (rst) begin
      mon_busy  = 0;
      mon_loads = 0;
    end else begin
      if (busy) begin
        mon_busy++;
        if (load) begin
          mon_loads++;
          chk("load_entrada", int'(entrada), tb_low);
          chk("load_ud", int'(ud), 1);
        end else if (seq.size() > 0) begin
          chk("count_seq", int'(cnt_out), int'(seq.pop_front()));
        end
      end else if (load) begin
        chk("load_outside_busy", 1, 0);
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t r;
          r = sb.pop_front();
          chk("busy_cycles", mon_busy, r.busy);
          chk("sweeps_done", int'(sweeps_done), r.sweeps);
          chk("error_flag", int'(error), r.err);
          chk("load_count", mon_loads, r.loads);
          chk("busy_in_done", int'(busy), 0);
        end
        mon_busy  = 0;
        mon_loads = 0;
      end
    end
  end

  // One run from the host side; force_at / mid_start are busy-cycle indices (0 = unused).
  task automatic do_run(input int l, input int h, input int n, input int force_at, input int mid_start);
    exp_t       r;
    logic [3:0] v;
    logic [3:0] q[$];
    int         c;
    bit         valid;
    valid = (l < h) && (n != 0);
    if (valid) begin
      v = 4'(l);
      q.push_back(v);
      for (int t = 0; t < n; t++) begin
        while (v != 4'(h)) begin v = next_count(v, 1'b0, 4'd0, 1'b1); q.push_back(v); end
        while (v != 4'(l)) begin v = next_count(v, 1'b0, 4'd0, 1'b0); q.push_back(v); end
      end
      r.busy = 2 + 2 * (h - l) * n;
      r.sweeps = n;
      r.err = 0;
      r.loads = 1;
      if (force_at > 0) begin
        r.busy = force_at;
        r.sweeps = (force_at - 3) / (2 * (h - l));
        r.err = 1;
        while (q.size() > force_at - 1) void'(q.pop_back());
      end
      foreach (q[i]) seq.push_back(q[i]);
    end else begin
      r.busy = 0;
      r.sweeps = model_sweeps;
      r.err = 1;
      r.loads = 0;
    end
    model_sweeps = r.sweeps;
    tb_low = l;
    sb.push_back(r);
    low = 4'(l);
    high = 4'(h);
    nsw = 4'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    low = 4'($urandom);
    high = 4'($urandom);
    nsw = 4'($urandom);
    if (!valid) begin
      chk("reject_done_latency", int'(done), 1);
      chk("reject_busy", int'(busy), 0);
    end
    for (c = 1; c < 400; c++) begin
      if (done) break;
      if (c == force_at) force_zero = 1'b1;
      if (c == mid_start) start = 1'b1;
      @(negedge clk);
      force_zero = 1'b0;
      start = 1'b0;
    end
    if (!done) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("sweeps_hold", int'(sweeps_done), r.sweeps);
    chk("error_hold", int'(error), r.err);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_load", int'(load), 0);
    chk("rst_entrada", int'(entrada), 0);
    chk("rst_ud", int'(ud), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_sweeps", int'(sweeps_done), 0);
    rst = 1'b0;
    @(negedge clk);

    do_run(2, 5, 1, 0, 0);
    do_run(0, 15, 2, 0, 0);
    do_run(7, 7, 1, 0, 0);
    do_run(3, 9, 0, 0, 0);
    do_run(3, 9, 3, 16, 0);
    do_run(1, 6, 2, 0, 5);

    // Reset in the middle of the DOWN phase, then a clean run.
    tb_low = 3;
    low = 4'd3; high = 4'd9; nsw = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_load", int'(load), 0);
    chk("midrst_entrada", int'(entrada), 0);
    chk("midrst_ud", int'(ud), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_error", int'(error), 0);
    chk("midrst_sweeps", int'(sweeps_done), 0);
    rst = 1'b0;
    model_sweeps = 0;
    @(negedge clk);
    do_run(1, 4, 1, 0, 0);

    for (int k = 0; k < 14; k++) begin
      int l, h, n;
      if ($urandom_range(0, 4) == 0) begin
        l = $urandom_range(0, 15);
        h = $urandom_range(0, l);
        n = $urandom_range(0, 3);
      end else begin
        l = $urandom_range(0, 14);
        h = $urandom_range(l + 1, 15);
        n = $urandom_range(1, 3);
      end
      do_run(l, h, n, 0, ($urandom_range(0, 1) == 1) ? 3 : 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    chk("scoreboard_empty", sb.size(), 0);
    chk("sequence_empty", seq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
